multicycle_ctrl_fsm: RTL and testbench



---
 rtl/rv_ctrl_pkg.sv | 61 ++++++
 rtl/opcode_classifier.sv | 36 +++
 rtl/multicycle_ctrl_fsm.sv | 181 ++++++++++++++++++
 tb/tb_multicycle_ctrl_fsm.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// rv_ctrl_pkg
// Shared definitions for the RV32I multi-cycle control path: base opcode
// values, sequencer state encoding, opcode-class encoding and the encodings
// of the PC-source and write-back mux selects. Imported by the sequencer,
// the opcode classifier and by benches that need the opcode values.
// ---------------------------------------------------------------------------
package rv_ctrl_pkg;

  // RV32I base opcodes (IR[6:0])
  localparam logic [6:0] OPC_R     = 7'b0110011;
  localparam logic [6:0] OPC_IALU  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;
  localparam logic [6:0] OPC_BR    = 7'b1100011;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;
  localparam logic [6:0] OPC_JAL   = 7'b1101111;
  localparam logic [6:0] OPC_JALR  = 7'b1100111;

  // Sequencer states
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_TRAP   = 3'd6
  } state_e;

  // Opcode classes latched in DECODE
  typedef enum logic [3:0] {
    CLS_R     = 4'd0,
    CLS_IALU  = 4'd1,
    CLS_LOAD  = 4'd2,
    CLS_STORE = 4'd3,
    CLS_BR    = 4'd4,
    CLS_LUI   = 4'd5,
    CLS_AUIPC = 4'd6,
    CLS_JAL   = 4'd7,
    CLS_JALR  = 4'd8
  } op_class_e;

  // pc_src encoding
  localparam logic [1:0] PC_SRC_PLUS4  = 2'd0;
  localparam logic [1:0] PC_SRC_BRANCH = 2'd1;
  localparam logic [1:0] PC_SRC_JAL    = 2'd2;
  localparam logic [1:0] PC_SRC_JALR   = 2'd3;

  // wb_sel encoding
  localparam logic [1:0] WB_SEL_ALU = 2'd0;
  localparam logic [1:0] WB_SEL_MEM = 2'd1;
  localparam logic [1:0] WB_SEL_PC4 = 2'd2;

  // True for classes that need a data-memory access after EXEC
  function automatic logic is_mem_class(input op_class_e cls);
    return (cls == CLS_LOAD) || (cls == CLS_STORE);
  endfunction

endpackage

// File: rtl/opcode_classifier.sv
// ---------------------------------------------------------------------------
// opcode_classifier
// Purely combinational map from an RV32I opcode to its instruction class.
// Opcodes outside the base set raise illegal_o; class_o is then don't-care
// (driven to CLS_R).
//   opcode_i  in  7  instruction opcode field
//   class_o   out 4  op_class_e value
//   illegal_o out 1  opcode is not an RV32I base opcode
// ---------------------------------------------------------------------------
module opcode_classifier
  import rv_ctrl_pkg::*;
(
  input  logic [6:0] opcode_i,
  output logic [3:0] class_o,
  output logic       illegal_o
);

  // Opcode decode table
  always_comb begin
    class_o   = CLS_R;
    illegal_o = 1'b0;
    case (opcode_i)
      OPC_R:     class_o = CLS_R;
      OPC_IALU:  class_o = CLS_IALU;
      OPC_LOAD:  class_o = CLS_LOAD;
      OPC_STORE: class_o = CLS_STORE;
      OPC_BR:    class_o = CLS_BR;
      OPC_LUI:   class_o = CLS_LUI;
      OPC_AUIPC: class_o = CLS_AUIPC;
      OPC_JAL:   class_o = CLS_JAL;
      OPC_JALR:  class_o = CLS_JALR;
      default:   illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// ---------------------------------------------------------------------------
// multicycle_ctrl_fsm
// Multi-cycle RV32I sequencer: FETCH/DECODE/EXEC/MEM/WB over one shared
// instruction/data memory port with a req/ready handshake. Drives datapath
// write enables and mux selects and counts retired instructions.
//   clk           in   system clock, rising edge
//   rst_n         in   synchronous active-low reset
//   run           in   leave IDLE and start sequencing (sampled in IDLE only)
//   opcode        in   7-bit opcode from IR
//   branch_taken  in   branch compare result (used in EXEC of a branch)
//   mem_ready     in   memory completes the current access this cycle
//   mem_req       out  memory access request
//   mem_we        out  store access
//   mem_is_instr  out  access is an instruction fetch
//   ir_we         out  load IR from memory read data
//   pc_we         out  update PC
//   pc_src        out  PC source select
//   reg_we        out  register-file write
//   wb_sel        out  write-back source select
//   trap          out  illegal-opcode flag, held until reset
//   retire        out  one-cycle pulse per completed instruction
//   retired_cnt   out  32-bit wrapping retired-instruction counter
// ---------------------------------------------------------------------------
module multicycle_ctrl_fsm
  import rv_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
  input  logic [6:0]  opcode,
  input  logic        branch_taken,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic        mem_is_instr,
  output logic        ir_we,
  output logic        pc_we,
  output logic [1:0]  pc_src,
  output logic        reg_we,
  output logic [1:0]  wb_sel,
  output logic        trap,
  output logic        retire,
  output logic [31:0] retired_cnt
);

  state_e      state_q, state_d;
  op_class_e   cls_q, cls_d;
  logic [31:0] cnt_q;

  logic [3:0]  dec_class_s;
  logic        dec_illegal_s;

  opcode_classifier u_classifier (
    .opcode_i  (opcode),
    .class_o   (dec_class_s),
    .illegal_o (dec_illegal_s)
  );

  // State and latched opcode class
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cls_q   <= CLS_R;
    end else begin
      state_q <= state_d;
      cls_q   <= cls_d;
    end
  end

  // Next-state logic; the class is captured only in DECODE so later IR
  // changes cannot alter the remaining steps of the instruction
  always_comb begin
    state_d = state_q;
    cls_d   = cls_q;
    case (state_q)
      ST_IDLE: begin
        if (run) state_d = ST_FETCH;
        else     state_d = ST_IDLE;
      end
      ST_FETCH: begin
        if (mem_ready) state_d = ST_DECODE;
        else           state_d = ST_FETCH;
      end
      ST_DECODE: begin
        if (dec_illegal_s) begin
          state_d = ST_TRAP;
        end else begin
          cls_d   = op_class_e'(dec_class_s);
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (cls_q == CLS_BR)          state_d = ST_FETCH;
        else if (is_mem_class(cls_q)) state_d = ST_MEM;
        else                          state_d = ST_WB;
      end
      ST_MEM: begin
        if (!mem_ready)               state_d = ST_MEM;
        else if (cls_q == CLS_STORE)  state_d = ST_FETCH;
        else                          state_d = ST_WB;
      end
      ST_WB:   state_d = ST_FETCH;
      // Only reset leaves TRAP; run is deliberately ignored here
      ST_TRAP: state_d = ST_TRAP;
      default: state_d = ST_IDLE;
    endcase
  end

  // Output decode: Moore on state/class, with the memory-waiting states
  // qualifying their completion strobes on mem_ready
  always_comb begin
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_is_instr = 1'b0;
    ir_we        = 1'b0;
    pc_we        = 1'b0;
    pc_src       = PC_SRC_PLUS4;
    reg_we       = 1'b0;
    wb_sel       = WB_SEL_ALU;
    trap         = 1'b0;
    retire       = 1'b0;
    case (state_q)
      ST_IDLE:   ;
      ST_FETCH: begin
        mem_req      = 1'b1;
        mem_is_instr = 1'b1;
        ir_we        = mem_ready;
      end
      ST_DECODE: ;
      ST_EXEC: begin
        if (cls_q == CLS_BR) begin
          pc_we  = 1'b1;
          pc_src = branch_taken ? PC_SRC_BRANCH : PC_SRC_PLUS4;
          retire = 1'b1;
        end else begin
          pc_we  = 1'b0;
        end
      end
      ST_MEM: begin
        mem_req = 1'b1;
        mem_we  = (cls_q == CLS_STORE);
        if (cls_q == CLS_STORE) begin
          pc_we  = mem_ready;
          retire = mem_ready;
        end else begin
          pc_we  = 1'b0;
        end
      end
      ST_WB: begin
        reg_we = 1'b1;
        pc_we  = 1'b1;
        retire = 1'b1;
        case (cls_q)
          CLS_LOAD: wb_sel = WB_SEL_MEM;
          CLS_JAL:  wb_sel = WB_SEL_PC4;
          CLS_JALR: wb_sel = WB_SEL_PC4;
          default:  wb_sel = WB_SEL_ALU;
        endcase
        case (cls_q)
          CLS_JAL:  pc_src = PC_SRC_JAL;
          CLS_JALR: pc_src = PC_SRC_JALR;
          default:  pc_src = PC_SRC_PLUS4;
        endcase
      end
      ST_TRAP:   trap = 1'b1;
      default:   ;
    endcase
  end

  // Retired-instruction counter, wraps naturally at 32 bits
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= 32'd0;
    end else if (retire) begin
      cnt_q <= cnt_q + 32'd1;
    end
  end

  assign retired_cnt = cnt_q;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
module tb_multicycle_ctrl_fsm;
  import rv_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        run;
  logic [6:0]  opcode;
  logic        branch_taken;
  logic        mem_ready;
  logic        mem_req, mem_we, mem_is_instr, ir_we, pc_we, reg_we, trap, retire;
  logic [1:0]  pc_src, wb_sel;
  logic [31:0] retired_cnt;

  multicycle_ctrl_fsm dut (
    .clk(clk), .rst_n(rst_n), .run(run), .opcode(opcode),
    .branch_taken(branch_taken), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_is_instr(mem_is_instr),
    .ir_we(ir_we), .pc_we(pc_we), .pc_src(pc_src), .reg_we(reg_we),
    .wb_sel(wb_sel), .trap(trap), .retire(retire), .retired_cnt(retired_cnt)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  typedef struct {
    logic [1:0]  pc_src;
    logic [1:0]  wb_sel;
    int          n_regwe;
    int          cycles;
    logic [31:0] cnt;
  } instr_exp_t;

  typedef struct {
    logic we;
    logic is_instr;
    int   held;
  } mem_exp_t;

  instr_exp_t iq[$];
  mem_exp_t   mq[$];

  int fetch_wait = 0;
  int data_wait  = 0;

  // Directed vectors: opcode, taken, fetch wait, data wait, mem kind
  // (0 none, 1 load, 2 store), expected pc_src, wb_sel, reg_we count, cycles
  localparam int NV = 10;
  logic [6:0] t_op    [NV] = '{7'b0110011, 7'b0000011, 7'b1100011, 7'b1100011, 7'b1101111,
                               7'b1100111, 7'b0100011, 7'b0010011, 7'b0110111, 7'b0010111};
  logic       t_tk    [NV] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  int         t_fw    [NV] = '{0, 0, 0, 0, 0, 0, 0, 1, 0, 2};
  int         t_mw    [NV] = '{0, 2, 0, 0, 0, 0, 1, 0, 0, 0};
  int         t_mk    [NV] = '{0, 1, 0, 0, 0, 0, 2, 0, 0, 0};
  logic [1:0] t_pcsrc [NV] = '{2'd0, 2'd0, 2'd1, 2'd0, 2'd2, 2'd3, 2'd0, 2'd0, 2'd0, 2'd0};
  logic [1:0] t_wbsel [NV] = '{2'd0, 2'd1, 2'd0, 2'd0, 2'd2, 2'd2, 2'd0, 2'd0, 2'd0, 2'd0};
  int         t_nrw   [NV] = '{1, 1, 0, 0, 1, 1, 0, 1, 1, 1};
  int         t_cyc   [NV] = '{4, 7, 3, 3, 4, 4, 5, 5, 4, 6};

  // Memory responder: asserts mem_ready after the configured number of waits
  initial begin
    int wc;
    int cw;
    wc = 0;
    mem_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (mem_req) begin
        cw = mem_is_instr ? fetch_wait : data_wait;
        if (wc >= cw) begin
          mem_ready = 1'b1;
          wc = 0;
        end else begin
          mem_ready = 1'b0;
          wc++;
        end
      end else begin
        mem_ready = 1'b0;
        wc = 0;
      end
    end
  end

  // Instruction monitor: compares each retire against the scoreboard
  initial begin
    bit in_i;
    int cyc, nr, np, ni;
    instr_exp_t e;
    in_i = 1'b0; cyc = 0; nr = 0; np = 0; ni = 0;
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) begin
        in_i = 1'b0;
      end else begin
        if (!in_i && mem_req && mem_is_instr) begin
          in_i = 1'b1; cyc = 0; nr = 0; np = 0; ni = 0;
        end
        if (in_i) begin
          cyc++;
          nr += int'(reg_we);
          np += int'(pc_we);
          ni += int'(ir_we);
        end
        if (retire) begin
          if (!in_i || iq.size() == 0) begin
            n_total++;
            $display("FAIL retire_unexpected: got retire=1, expected no retire");
          end else begin
            e = iq.pop_front();
            check("pc_src",      32'(pc_src),  32'(e.pc_src));
            check("wb_sel",      32'(wb_sel),  32'(e.wb_sel));
            check("reg_we_cnt",  32'(nr),      32'(e.n_regwe));
            check("pc_we_cnt",   32'(np),      32'd1);
            check("ir_we_cnt",   32'(ni),      32'd1);
            check("cycles",      32'(cyc),     32'(e.cycles));
            check("retired_cnt", retired_cnt,  e.cnt);
          end
          in_i = 1'b0;
        end
      end
    end
  end

  // Memory monitor: checks each completed access for kind, stability, length
  initial begin
    int held;
    bit unstable;
    logic we0, in0;
    mem_exp_t m;
    held = 0; unstable = 1'b0; we0 = 1'b0; in0 = 1'b0;
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) begin
        held = 0; unstable = 1'b0;
      end else if (mem_req) begin
        if (held == 0) begin
          we0 = mem_we; in0 = mem_is_instr;
        end else if (mem_we !== we0 || mem_is_instr !== in0) begin
          unstable = 1'b1;
        end
        held++;
        if (mem_ready) begin
          if (mq.size() == 0) begin
            n_total++;
            $display("FAIL mem_unexpected: got access we=%0b instr=%0b, expected none", mem_we, mem_is_instr);
          end else begin
            m = mq.pop_front();
            check("mem_we",       32'(mem_we),       32'(m.we));
            check("mem_is_instr", 32'(mem_is_instr), 32'(m.is_instr));
            check("mem_held",     32'(held),         32'(m.held));
            check("mem_stable",   32'(unstable),     32'd0);
          end
          held = 0; unstable = 1'b0;
        end
      end else begin
        held = 0; unstable = 1'b0;
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #3;
  endtask

  task automatic wait_retire(input string name);
    bit got;
    got = 1'b0;
    for (int k = 0; k < 40 && !got; k++) begin
      step();
      if (retire) got = 1'b1;
    end
    if (!got) begin
      n_total++;
      $display("FAIL %s: got no retire within 40 cycles, expected retire", name);
    end
  endtask

  task automatic issue(input logic [6:0] op, input logic tk, input int fw, input int mw,
                       input int mk, input logic [1:0] ps, input logic [1:0] ws,
                       input int nrw, input int cyc, input logic [31:0] cnt);
    instr_exp_t e;
    mem_exp_t   m;
    opcode = op; branch_taken = tk; fetch_wait = fw; data_wait = mw;
    m.we = 1'b0; m.is_instr = 1'b1; m.held = fw + 1;
    mq.push_back(m);
    if (mk != 0) begin
      m.we = (mk == 2); m.is_instr = 1'b0; m.held = mw + 1;
      mq.push_back(m);
    end
    e.pc_src = ps; e.wb_sel = ws; e.n_regwe = nrw; e.cycles = cyc; e.cnt = cnt;
    iq.push_back(e);
    run = 1'b1;
    wait_retire("retire_timeout");
  endtask

  initial begin
    logic [15:0] outs;
    mem_exp_t    m;
    bit          got;
    rst_n = 1'b0; run = 1'b0; opcode = 7'd0; branch_taken = 1'b0;
    repeat (2) step();
    outs = {mem_req, mem_we, mem_is_instr, ir_we, pc_we, pc_src, reg_we, wb_sel, trap, retire, 3'b000};
    check("reset_outputs", 32'(outs), 32'd0);
    check("reset_cnt", retired_cnt, 32'd0);
    rst_n = 1'b1;

    // Back-to-back directed instructions
    for (int i = 0; i < NV; i++)
      issue(t_op[i], t_tk[i], t_fw[i], t_mw[i], t_mk[i], t_pcsrc[i], t_wbsel[i],
            t_nrw[i], t_cyc[i], 32'(i));

    // Illegal opcode: TRAP right after DECODE, sticky with run high
    opcode = 7'b1111111; fetch_wait = 0;
    m.we = 1'b0; m.is_instr = 1'b1; m.held = 1;
    mq.push_back(m);
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      step();
      if (ir_we) got = 1'b1;
    end
    check("trap_fetch_seen", 32'(got), 32'd1);
    step();
    check("trap_in_decode", 32'(trap), 32'd0);
    step();
    check("trap_set", 32'(trap), 32'd1);
    for (int k = 0; k < 10; k++) begin
      step();
      check("trap_held", 32'({trap, mem_req, reg_we, pc_we, retire}), 32'b10000);
      check("trap_cnt", retired_cnt, 32'd10);
    end
    rst_n = 1'b0; run = 1'b0;
    step();
    check("trap_cleared", 32'(trap), 32'd0);
    check("trap_reset_idle", 32'(dut.state_q), 32'(ST_IDLE));
    rst_n = 1'b1;

    // Reset while the fetch is waiting on memory
    opcode = 7'b0110011; fetch_wait = 5; run = 1'b1;
    got = 1'b0;
    for (int k = 0; k < 10 && !got; k++) begin
      step();
      if (mem_req) got = 1'b1;
    end
    check("fetch_started", 32'(got), 32'd1);
    step();
    check("fetch_waiting", 32'({mem_req, mem_is_instr, mem_we}), 32'b110);
    rst_n = 1'b0; run = 1'b0;
    step();
    check("abort_mem_req", 32'(mem_req), 32'd0);
    check("abort_idle", 32'(dut.state_q), 32'(ST_IDLE));
    rst_n = 1'b1;
    step();

    // Counter wrap from 0xFFFF_FFFF
    dut.cnt_q = 32'hFFFF_FFFF;
    issue(7'b0110011, 1'b0, 0, 0, 0, 2'd0, 2'd0, 1, 4, 32'hFFFF_FFFF);
    fetch_wait = 3;
    step();
    check("cnt_wrap", retired_cnt, 32'd0);
    check("next_fetch", 32'(mem_req), 32'd1);
    rst_n = 1'b0; run = 1'b0;
    step();
    rst_n = 1'b1;
    repeat (3) step();
    check("instr_queue_drained", 32'(iq.size()), 32'd0);
    check("mem_queue_drained", 32'(mq.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
